outlier_drain: RTL and testbench
================================

Name: outlier_drain

Overview:
- Sits directly downstream of the validator controller's outlier FIFO.
- Pops outlier point positions from the FIFO, which has 1-cycle read latency, and re-emits them as a valid/ready stream with a last-beat marker.
- Counts outliers, flags out-of-range positions, and raises a completion flag once the controller is done and the FIFO is fully drained.

Parameters:
- N, 16, width of one outlier position word; also the FIFO dout width.
- EMPTY_GUARD, 2, consecutive cycles i_fifo_empty must stay high after i_ctrl_done before the drain is declared complete; must be >=1.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_start  input  1  single-cycle pulse; arms a new drain pass.
- i_fifo_data  input  N  FIFO dout; valid the cycle after o_fifo_rd.
- i_fifo_empty  input  1  FIFO empty flag.
- o_fifo_rd  output  1  FIFO read enable.
- i_ctrl_done  input  1  controller has finished validating the cloud.
- i_point_cloud_size  input  2N  number of points in the cloud; used only for the range check.
- m_data  output  N  outlier position.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from the consumer.
- m_last  output  1  marks the final outlier beat.
- o_outlier_count  output  2N  beats accepted in this pass.
- o_range_err  output  1  sticky; an emitted position was >= i_point_cloud_size.
- o_busy  output  1  high while in DRAIN or FLUSH.
- o_done  output  1  pass complete; held until the next i_start or reset.

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - All outputs 0; o_outlier_count=0.
  - Skid buffer cleared; in-flight flag cleared; guard counter cleared.
  - Reset mid-pass discards all buffered data, with no partial m_last.
- States: IDLE, DRAIN, FLUSH, DONE.
  - IDLE->DRAIN on i_start.
  - DONE->DRAIN on i_start; this clears o_done, o_outlier_count and o_range_err on the same edge.
  - i_start is ignored in DRAIN and FLUSH.
- Storage:
  - 2-entry FIFO-ordered skid buffer, occupancy occ in 0..2.
  - rd_inflight register: set the cycle after o_fifo_rd, meaning data is captured on that edge.
- Read rule:
  - o_fifo_rd = (state==DRAIN) && !i_fifo_empty && (occ + rd_inflight < 2).
  - o_fifo_rd is combinational from registered state and i_fifo_empty.
  - Data returned via rd_inflight is always written into the skid buffer; overflow cannot occur by construction.
- Guard counter:
  - In DRAIN with i_ctrl_done=1, i_fifo_empty=1 and rd_inflight=0: increments, saturating at EMPTY_GUARD.
  - Any other condition in DRAIN resets it to 0.
  - end_known is set when the counter reaches EMPTY_GUARD. The transition DRAIN->FLUSH happens on that same edge.
- Hold-back rule (keeps m_last stable once m_valid rises):
  - In DRAIN: m_valid = (occ==2).
  - In FLUSH: m_valid = (occ>=1).
  - m_data = head entry.
  - m_last = (state==FLUSH) && (occ==1).
- Handshake:
  - A beat transfers when m_valid && m_ready.
  - m_data, m_last and m_valid must not change while m_valid=1 && m_ready=0.
  - A pop and a push in the same cycle leave occ unchanged, with order preserved.
- On each transfer:
  - o_outlier_count increments by 1, width 2N, wrap not expected.
  - If m_data (zero-extended to 2N) >= i_point_cloud_size, o_range_err is set; the beat is still emitted.
- FLUSH->DONE:
  - When occ==0, either on entry with zero outliers or after the m_last transfer.
  - o_done=1 from the next cycle.
  - A zero-outlier pass emits no beats and never asserts m_last.
- o_busy = (state==DRAIN || state==FLUSH).
- Simultaneous events:
  - i_fifo_empty deasserting in the same cycle the guard would complete: guard resets and stays in DRAIN.
  - i_ctrl_done falling in DRAIN: guard resets.
  - After FLUSH is entered, i_ctrl_done and i_fifo_empty are ignored.

Test Plan:
- Zero outliers: i_start, i_ctrl_done=1, empty=1 throughout -> o_fifo_rd never high. FLUSH entered 2 cycles after guard start, DONE next; o_done=1, o_outlier_count=0, no m_valid.
- Three outliers 5, 9, 12 preloaded, m_ready=1, ctrl_done raised after the FIFO empties -> beats 5, 9, 12 in order; m_last only on 12; o_outlier_count=3; o_range_err=0.
- Backpressure: 4 entries, m_ready toggled 1/0 each cycle -> m_data/m_last stable while stalled; never more than 2 reads outstanding plus buffered; order preserved; count=4.
- Late write: i_ctrl_done=1 while empty=1 for 1 cycle, then one entry 7 arrives -> guard resets; 7 later emitted with m_last=1; count=1.
- Range check: i_point_cloud_size=100, outliers 99, 100 -> both emitted; o_range_err rises after the 100 transfer and stays high until the next i_start.
- Reset mid-pass: reset=0 while occ==2 and m_valid=1 -> outputs 0 immediately (async). After release and i_start, a fresh pass with entry 3 yields count=1 and no stale beats.

Source files
------------

// File: rtl/outlier_drain_if.sv
// Outlier stream interface: position word, valid/ready handshake and last-beat marker.
interface outlier_drain_if #(
    parameter int N = 16
) ();
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    // Producer side drives the beat, consumer side drives ready.
    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/outlier_drain.sv
// Drains outlier positions from a 1-cycle-latency FIFO into a valid/ready stream.
// A 2-entry skid buffer holds returned words. While draining, the stream only
// offers a beat when both entries are full. This guarantees that the beat shown
// is never the final one, so m_last can be decided once the end is known and
// never changes under backpressure.
module outlier_drain #(
    parameter int N           = 16,
    parameter int EMPTY_GUARD = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic [N-1:0]     i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_fifo_rd,
    input  logic             i_ctrl_done,
    input  logic [2*N-1:0]   i_point_cloud_size,
    outlier_drain_if.master  m_if,
    output logic [2*N-1:0]   o_outlier_count,
    output logic             o_range_err,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = 2 * N;
    localparam int GW = $clog2(EMPTY_GUARD + 1);
    localparam logic [GW-1:0] GUARD_MAX = GW'(EMPTY_GUARD);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    state_t          state_q;
    logic [1:0]      occ_q, occ_d, occ_after_pop;
    logic [N-1:0]    head_q, head_d;
    logic [N-1:0]    tail_q, tail_d;
    logic            inflight_q;
    logic [GW-1:0]   guard_q, guard_d;
    logic [CW-1:0]   count_q;
    logic            range_err_q;
    logic            done_q;
    logic            valid;
    logic            pop;
    logic            guard_hit;

    // Read issue, stream presentation, skid-buffer next state and guard next value.
    always_comb begin
        o_fifo_rd = (state_q == DRAIN) && !i_fifo_empty
                    && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);

        valid = 1'b0;
        if (state_q == DRAIN) begin
            valid = (occ_q == 2'd2);
        end else if (state_q == FLUSH) begin
            valid = (occ_q != 2'd0);
        end
        pop = valid && m_if.m_ready;

        head_d        = head_q;
        tail_d        = tail_q;
        occ_after_pop = occ_q;
        if (pop) begin
            head_d        = tail_q;
            occ_after_pop = occ_q - 2'd1;
        end
        occ_d = occ_after_pop;
        if (inflight_q) begin
            if (occ_after_pop == 2'd0) begin
                head_d = i_fifo_data;
            end else begin
                tail_d = i_fifo_data;
            end
            occ_d = occ_after_pop + 2'd1;
        end

        guard_hit = i_ctrl_done && i_fifo_empty && !inflight_q;
        guard_d   = '0;
        if (guard_hit) begin
            guard_d = (guard_q == GUARD_MAX) ? guard_q : guard_q + GW'(1);
        end
    end

    // Control FSM together with buffer, in-flight, counter and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            occ_q       <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            inflight_q  <= 1'b0;
            guard_q     <= '0;
            count_q     <= '0;
            range_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= o_fifo_rd;
            if (pop) begin
                count_q <= count_q + CW'(1);
                if ({{N{1'b0}}, head_q} >= i_point_cloud_size) begin
                    range_err_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE, DONE: begin
                    if (i_start) begin
                        state_q     <= DRAIN;
                        done_q      <= 1'b0;
                        count_q     <= '0;
                        range_err_q <= 1'b0;
                        guard_q     <= '0;
                    end
                end
                DRAIN: begin
                    guard_q <= guard_d;
                    if (guard_d == GUARD_MAX) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (occ_q == 2'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_if.m_data   = head_q;
    assign m_if.m_valid  = valid;
    assign m_if.m_last   = (state_q == FLUSH) && (occ_q == 2'd1);
    assign o_outlier_count = count_q;
    assign o_range_err   = range_err_q;
    assign o_busy        = (state_q == DRAIN) || (state_q == FLUSH);
    assign o_done        = done_q;

endmodule

// File: tb/tb_outlier_drain.sv
// Self-checking bench for outlier_drain. It includes a queue-based FIFO with
// 1-cycle read latency and a scoreboard of expected beats. Each cycle, the
// monitor checks the stream order, m_last, count, range flag and stall
// stability against that scoreboard.
module tb_outlier_drain;

    localparam int N           = 16;
    localparam int CW          = 2 * N;
    localparam int EMPTY_GUARD = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_start = 1'b0;
    logic [N-1:0]  i_fifo_data = '0;
    logic          i_fifo_empty = 1'b1;
    logic          o_fifo_rd;
    logic          i_ctrl_done = 1'b0;
    logic [CW-1:0] i_point_cloud_size = CW'(100);
    logic [CW-1:0] o_outlier_count;
    logic          o_range_err;
    logic          o_busy;
    logic          o_done;

    outlier_drain_if #(.N(N)) mIf ();

    outlier_drain #(.N(N), .EMPTY_GUARD(EMPTY_GUARD)) dut (
        .clock              (clock),
        .reset              (reset),
        .i_start            (i_start),
        .i_fifo_data        (i_fifo_data),
        .i_fifo_empty       (i_fifo_empty),
        .o_fifo_rd          (o_fifo_rd),
        .i_ctrl_done        (i_ctrl_done),
        .i_point_cloud_size (i_point_cloud_size),
        .m_if               (mIf),
        .o_outlier_count    (o_outlier_count),
        .o_range_err        (o_range_err),
        .o_busy             (o_busy),
        .o_done             (o_done)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    logic [N-1:0] fifoQ[$];
    logic [N-1:0] expQ[$];
    int           readsIssued = 0;
    int           beatsTaken  = 0;
    int           modelCount  = 0;
    bit           modelRange  = 1'b0;
    bit           rdSeen      = 1'b0;
    bit           prevStall   = 1'b0;
    logic [N-1:0] prevData    = '0;
    logic         prevLast    = 1'b0;
    int           readyMode   = 0;
    int           nChecks     = 0;
    int           nFail       = 0;

    task automatic monitor();
        bit expLast;
        nChecks++;
        if (readsIssued - beatsTaken > 2) begin
            nFail++;
            $display("[TB] FAIL outstanding: reads-beats=%0d required<=2", readsIssued - beatsTaken);
        end
        nChecks++;
        if (o_outlier_count !== CW'(modelCount)) begin
            nFail++;
            $display("[TB] FAIL count: got %0d expected %0d", o_outlier_count, modelCount);
        end
        nChecks++;
        if (o_range_err !== modelRange) begin
            nFail++;
            $display("[TB] FAIL range_err: got %b expected %b", o_range_err, modelRange);
        end
        if (prevStall) begin
            nChecks++;
            if (mIf.m_valid !== 1'b1 || mIf.m_data !== prevData || mIf.m_last !== prevLast) begin
                nFail++;
                $display("[TB] FAIL stall_hold: got v=%b d=%0d l=%b expected v=1 d=%0d l=%b",
                         mIf.m_valid, mIf.m_data, mIf.m_last, prevData, prevLast);
            end
        end
        if (mIf.m_valid === 1'b1) begin
            nChecks++;
            if (expQ.size() == 0) begin
                nFail++;
                $display("[TB] FAIL spurious_valid: got m_valid=1 data=%0d expected no beat", mIf.m_data);
            end
        end
        if (mIf.m_valid === 1'b1 && mIf.m_ready === 1'b1 && expQ.size() > 0) begin
            expLast = (expQ.size() == 1);
            nChecks++;
            if (mIf.m_data !== expQ[0] || mIf.m_last !== expLast) begin
                nFail++;
                $display("[TB] FAIL beat: got data=%0d last=%b expected data=%0d last=%b",
                         mIf.m_data, mIf.m_last, expQ[0], expLast);
            end
            modelCount++;
            if ({{N{1'b0}}, expQ[0]} >= i_point_cloud_size) modelRange = 1'b1;
            void'(expQ.pop_front());
            beatsTaken++;
        end
        rdSeen = (o_fifo_rd === 1'b1);
        if (rdSeen) begin
            readsIssued++;
            nChecks++;
            if (fifoQ.size() == 0) begin
                nFail++;
                $display("[TB] FAIL rd_when_empty: got o_fifo_rd=1 expected 0 with FIFO empty");
            end
        end
        prevStall = (mIf.m_valid === 1'b1) && (mIf.m_ready !== 1'b1);
        prevData  = mIf.m_data;
        prevLast  = mIf.m_last;
    endtask

    // One clock: sample at the falling edge, then update FIFO and consumer just after the rising edge.
    task automatic tick();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
        if (rdSeen && fifoQ.size() > 0) i_fifo_data = fifoQ.pop_front();
        i_fifo_empty = (fifoQ.size() == 0);
        case (readyMode)
            0: mIf.m_ready = 1'b1;
            1: mIf.m_ready = ~mIf.m_ready;
            2: mIf.m_ready = 1'($urandom_range(0, 1));
            default: mIf.m_ready = 1'b0;
        endcase
    endtask

    task automatic pushEntry(input logic [N-1:0] v);
        fifoQ.push_back(v);
        i_fifo_empty = 1'b0;
    endtask

    task automatic startPass(input logic [N-1:0] list[$], input logic [CW-1:0] size);
        expQ = list;
        i_point_cloud_size = size;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        modelCount  = 0;
        modelRange  = 1'b0;
        readsIssued = 0;
        beatsTaken  = 0;
    endtask

    task automatic waitFifoEmpty();
        int n = 0;
        while (fifoQ.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        nChecks++;
        if (fifoQ.size() != 0) begin
            nFail++;
            $display("[TB] FAIL fifo_drain_timeout: got %0d entries left expected 0", fifoQ.size());
        end
    endtask

    task automatic waitDone();
        int n = 0;
        while (o_done !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        nChecks++;
        if (o_done !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL done_timeout: got o_done=%b expected 1", o_done);
        end
    endtask

    task automatic finishPass(input int expCount);
        nChecks++;
        if (o_outlier_count !== CW'(expCount)) begin
            nFail++;
            $display("[TB] FAIL pass_count: got %0d expected %0d", o_outlier_count, expCount);
        end
        nChecks++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("[TB] FAIL missing_beats: got %0d unsent expected 0", expQ.size());
        end
        nChecks++;
        if (o_busy !== 1'b0 || mIf.m_valid !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL idle_after_done: got busy=%b valid=%b expected 0 0", o_busy, mIf.m_valid);
        end
        i_ctrl_done = 1'b0;
    endtask

    task automatic runPass(input logic [N-1:0] list[$], input logic [CW-1:0] size,
                           input int mode, input bit preload);
        readyMode = mode;
        if (preload) begin
            for (int i = 0; i < list.size(); i++) pushEntry(list[i]);
        end
        startPass(list, size);
        if (!preload) begin
            for (int i = 0; i < list.size(); i++) begin
                repeat ($urandom_range(0, 3)) tick();
                pushEntry(list[i]);
            end
        end
        waitFifoEmpty();
        repeat ($urandom_range(0, 2)) tick();
        i_ctrl_done = 1'b1;
        waitDone();
        finishPass(list.size());
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        repeat (2) tick();
        nChecks++;
        if (o_fifo_rd !== 1'b0 || mIf.m_valid !== 1'b0 || mIf.m_last !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL reset_stream: got rd=%b v=%b l=%b expected 0 0 0", o_fifo_rd, mIf.m_valid, mIf.m_last);
        end
        nChecks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_range_err !== 1'b0 || o_outlier_count !== '0) begin
            nFail++;
            $display("[TB] FAIL reset_status: got busy=%b done=%b err=%b cnt=%0d expected 0 0 0 0",
                     o_busy, o_done, o_range_err, o_outlier_count);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_zero_outliers();
        logic [N-1:0] q[$];
        int n = 0;
        readyMode = 0;
        i_ctrl_done = 1'b1;
        startPass(q, CW'(100));
        nChecks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL zero_busy: got busy=%b done=%b expected 1 0", o_busy, o_done);
        end
        while (o_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        nChecks++;
        if (n != EMPTY_GUARD + 1) begin
            nFail++;
            $display("[TB] FAIL zero_latency: got %0d cycles expected %0d", n, EMPTY_GUARD + 1);
        end
        nChecks++;
        if (readsIssued != 0) begin
            nFail++;
            $display("[TB] FAIL zero_reads: got %0d reads expected 0", readsIssued);
        end
        finishPass(0);
    endtask

    task automatic test_three();
        logic [N-1:0] q[$];
        q = '{16'd5, 16'd9, 16'd12};
        runPass(q, CW'(100), 0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [N-1:0] q[$];
        q = '{16'd21, 16'd4, 16'd33, 16'd17};
        runPass(q, CW'(100), 1, 1'b1);
    endtask

    task automatic test_late_write();
        logic [N-1:0] q[$];
        q = '{16'd7};
        readyMode = 0;
        i_ctrl_done = 1'b1;
        startPass(q, CW'(100));
        tick();
        nChecks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL late_busy: got busy=%b done=%b expected 1 0", o_busy, o_done);
        end
        pushEntry(16'd7);
        waitFifoEmpty();
        waitDone();
        finishPass(1);
    endtask

    task automatic test_range();
        logic [N-1:0] q[$];
        q = '{16'd99, 16'd100};
        runPass(q, CW'(100), 0, 1'b1);
        nChecks++;
        if (o_range_err !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL range_sticky: got %b expected 1", o_range_err);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] q[$];
        int len;
        for (int p = 0; p < 6; p++) begin
            q.delete();
            len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++) q.push_back(N'($urandom_range(0, 400)));
            runPass(q, CW'($urandom_range(100, 400)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_pass();
        logic [N-1:0] q[$];
        int n = 0;
        q = '{16'd11, 16'd22, 16'd33, 16'd44};
        readyMode = 3;
        mIf.m_ready = 1'b0;
        for (int i = 0; i < q.size(); i++) pushEntry(q[i]);
        startPass(q, CW'(100));
        while (mIf.m_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        nChecks++;
        if (mIf.m_valid !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL prefill_timeout: got m_valid=%b expected 1", mIf.m_valid);
        end
        reset = 1'b0;
        #1;
        nChecks++;
        if (mIf.m_valid !== 1'b0 || mIf.m_last !== 1'b0 || mIf.m_data !== '0 || o_fifo_rd !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL async_reset_stream: got v=%b l=%b d=%0d rd=%b expected 0 0 0 0",
                     mIf.m_valid, mIf.m_last, mIf.m_data, o_fifo_rd);
        end
        nChecks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_outlier_count !== '0) begin
            nFail++;
            $display("[TB] FAIL async_reset_status: got busy=%b done=%b cnt=%0d expected 0 0 0",
                     o_busy, o_done, o_outlier_count);
        end
        expQ.delete();
        fifoQ.delete();
        i_fifo_empty = 1'b1;
        modelCount  = 0;
        modelRange  = 1'b0;
        readsIssued = 0;
        beatsTaken  = 0;
        prevStall   = 1'b0;
        readyMode   = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        q = '{16'd3};
        runPass(q, CW'(100), 0, 1'b1);
    endtask

    // Bound the whole run so a stuck design still terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence followed by the summary line.
    initial begin
        mIf.m_ready = 1'b1;
        test_reset();
        test_zero_outliers();
        test_three();
        test_backpressure();
        test_late_write();
        test_range();
        test_random();
        test_reset_mid_pass();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
